// File: rtl/interboard_link_fifo.sv
// interboard_link_fifo
//   Board-to-board word link using a 4-phase Request/Ack handshake in both
//   directions. Outgoing words are queued in a TX FIFO so the game logic can
//   push bursts. Partner inputs are synchronised. Each TX handshake phase is
//   guarded by a timeout that sets a sticky error flag.
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   tx_valid/tx_data push side of the TX FIFO; tx_ready = FIFO not full
//   tx_count         words queued, including the word in flight
//   busy             TX FSM active or FIFO non-empty
//   Request_out, inter_data_out, Ack_in     outgoing handshake (Ack_in async)
//   Request_in, inter_data_in, Ack_out      incoming handshake (inputs async)
//   rx_valid/rx_data one-cycle pulse with the received word; rx_data holds
//   timeout_err      sticky timeout flag, cleared by clr_err (set wins)
module interboard_link_fifo #(
   parameter int unsigned DATA_W      = 6,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_valid,
   input  logic [DATA_W-1:0]             tx_data,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   tx_count,
   output logic                          busy,
   output logic                          Request_out,
   output logic [DATA_W-1:0]             inter_data_out,
   input  logic                          Ack_in,
   input  logic                          Request_in,
   input  logic [DATA_W-1:0]             inter_data_in,
   output logic                          Ack_out,
   output logic                          rx_valid,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          timeout_err,
   input  logic                          clr_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_WAIT_ACK, TX_WAIT_REL} tx_state_t;
   typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;

   tx_state_t tx_state;
   rx_state_t rx_state;

   // ---------------- input synchronisers (equal depth for req and data)
   logic [SYNC_STAGES-1:0] ack_sync;
   logic [SYNC_STAGES-1:0] req_sync;
   logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
   logic                   ack_s;
   logic                   req_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_sync <= '0;
         req_sync <= '0;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      end else begin
         ack_sync     <= {ack_sync[SYNC_STAGES-2:0], Ack_in};
         req_sync     <= {req_sync[SYNC_STAGES-2:0], Request_in};
         data_sync[0] <= inter_data_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign req_s = req_sync[SYNC_STAGES-1];

   // ---------------- TX FIFO + FSM
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [TW-1:0]     phase_cnt;
   logic              push;
   logic              pop;
   logic              tmo_armed;
   logic              tmo_hit;
   logic              active_nxt;
   logic [CW-1:0]     count_nxt;

   // Next-cycle view of pop/timeout/activity so that tx_count, tx_ready and
   // busy can be registered and still agree with the FSM on the same edge.
   always_comb begin
      push       = tx_valid && tx_ready;
      tmo_armed  = (TIMEOUT_CYC != 0) && (phase_cnt == TW'(TIMEOUT_CYC - 1));
      pop        = 1'b0;
      tmo_hit    = 1'b0;
      active_nxt = 1'b0;
      case (tx_state)
         TX_IDLE:     active_nxt = 1'b0;
         TX_SETUP:    active_nxt = 1'b1;
         TX_WAIT_ACK: begin
            pop        = ack_s;
            tmo_hit    = !ack_s && tmo_armed;
            active_nxt = !tmo_hit;
         end
         TX_WAIT_REL: begin
            tmo_hit    = ack_s && tmo_armed;
            active_nxt = ack_s && !tmo_hit;
         end
      endcase
      count_nxt = tx_count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state       <= TX_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         tx_count       <= '0;
         tx_ready       <= 1'b1;
         busy           <= 1'b0;
         Request_out    <= 1'b0;
         inter_data_out <= '0;
         phase_cnt      <= '0;
         timeout_err    <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= tx_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         tx_count <= count_nxt;
         tx_ready <= (count_nxt < CW'(FIFO_DEPTH));
         busy     <= active_nxt || (count_nxt != '0);

         if (tmo_hit)      timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;

         case (tx_state)
            TX_IDLE: begin
               phase_cnt <= '0;
               if (tx_count != '0) begin
                  inter_data_out <= mem[rd_ptr];
                  tx_state       <= TX_SETUP;
               end
            end
            TX_SETUP: begin
               phase_cnt   <= '0;
               Request_out <= 1'b1;
               tx_state    <= TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
               if (ack_s) begin
                  Request_out <= 1'b0;
                  phase_cnt   <= '0;
                  tx_state    <= TX_WAIT_REL;
               end else if (tmo_hit) begin
                  // word stays at the FIFO head and is re-requested
                  Request_out <= 1'b0;
                  phase_cnt   <= '0;
                  tx_state    <= TX_IDLE;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            TX_WAIT_REL: begin
               if (!ack_s || tmo_hit) begin
                  phase_cnt <= '0;
                  tx_state  <= TX_IDLE;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- RX FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         Ack_out  <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (req_s) begin
                  rx_data  <= data_sync[SYNC_STAGES-1];
                  rx_valid <= 1'b1;
                  Ack_out  <= 1'b1;
                  rx_state <= RX_ACK;
               end
            end
            RX_ACK: begin
               if (!req_s) begin
                  Ack_out  <= 1'b0;
                  rx_state <= RX_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interboard_link_fifo.sv
// Testbench for interboard_link_fifo.
//   a/b : 6-bit loop-back pair (TIMEOUT_CYC=10)
//   c   : 6-bit, depth 4, timeout disabled, bench acts as partner
//   d   : 6-bit, TIMEOUT_CYC=10, bench acts as partner
//   w   : 16-bit, depth 8, 3 sync stages, looped back onto itself
module tb_interboard_link_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- a/b pair
   logic a_tx_valid, b_tx_valid;
   logic [5:0] a_tx_data, b_tx_data;
   logic a_tx_ready, b_tx_ready;
   logic [2:0] a_tx_count, b_tx_count;
   logic a_busy, b_busy, a_req, b_req, a_ack_out, b_ack_out;
   logic [5:0] a_do, b_do, a_rxd, b_rxd;
   logic a_rxv, b_rxv, a_err, b_err;

   interboard_link_fifo #(.DATA_W(6), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) u_a (
      .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
      .tx_count(a_tx_count), .busy(a_busy), .Request_out(a_req), .inter_data_out(a_do),
      .Ack_in(b_ack_out), .Request_in(b_req), .inter_data_in(b_do), .Ack_out(a_ack_out),
      .rx_valid(a_rxv), .rx_data(a_rxd), .timeout_err(a_err), .clr_err(1'b0));

   interboard_link_fifo #(.DATA_W(6), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) u_b (
      .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
      .tx_count(b_tx_count), .busy(b_busy), .Request_out(b_req), .inter_data_out(b_do),
      .Ack_in(a_ack_out), .Request_in(a_req), .inter_data_in(a_do), .Ack_out(b_ack_out),
      .rx_valid(b_rxv), .rx_data(b_rxd), .timeout_err(b_err), .clr_err(1'b0));

   // ---------------- c: overflow, timeout disabled
   logic c_tx_valid, c_tx_ready, c_busy, c_req, c_pack, c_ack_out, c_rxv, c_err, c_en;
   logic [5:0] c_tx_data, c_do, c_rxd;
   logic [2:0] c_tx_count;

   interboard_link_fifo #(.DATA_W(6), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(0)) u_c (
      .clk(clk), .rst(rst), .tx_valid(c_tx_valid), .tx_data(c_tx_data), .tx_ready(c_tx_ready),
      .tx_count(c_tx_count), .busy(c_busy), .Request_out(c_req), .inter_data_out(c_do),
      .Ack_in(c_pack), .Request_in(1'b0), .inter_data_in(6'h00), .Ack_out(c_ack_out),
      .rx_valid(c_rxv), .rx_data(c_rxd), .timeout_err(c_err), .clr_err(1'b0));

   // ---------------- d: timeout / reset
   logic d_tx_valid, d_tx_ready, d_busy, d_req, d_pack, d_ack_out, d_rxv, d_err, d_en, d_clr;
   logic [5:0] d_tx_data, d_do, d_rxd;
   logic [2:0] d_tx_count;

   interboard_link_fifo #(.DATA_W(6), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) u_d (
      .clk(clk), .rst(rst), .tx_valid(d_tx_valid), .tx_data(d_tx_data), .tx_ready(d_tx_ready),
      .tx_count(d_tx_count), .busy(d_busy), .Request_out(d_req), .inter_data_out(d_do),
      .Ack_in(d_pack), .Request_in(1'b0), .inter_data_in(6'h00), .Ack_out(d_ack_out),
      .rx_valid(d_rxv), .rx_data(d_rxd), .timeout_err(d_err), .clr_err(d_clr));

   // ---------------- w: wide, self loop-back
   logic w_tx_valid, w_tx_ready, w_busy, w_req, w_ack_out, w_rxv, w_err;
   logic [15:0] w_tx_data, w_do, w_rxd;
   logic [3:0] w_tx_count;

   interboard_link_fifo #(.DATA_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(3), .TIMEOUT_CYC(0)) u_w (
      .clk(clk), .rst(rst), .tx_valid(w_tx_valid), .tx_data(w_tx_data), .tx_ready(w_tx_ready),
      .tx_count(w_tx_count), .busy(w_busy), .Request_out(w_req), .inter_data_out(w_do),
      .Ack_in(w_ack_out), .Request_in(w_req), .inter_data_in(w_do), .Ack_out(w_ack_out),
      .rx_valid(w_rxv), .rx_data(w_rxd), .timeout_err(w_err), .clr_err(1'b0));

   // ---------------- scoreboard queues and delivery counters
   logic [5:0]  exp_a[$], exp_b[$], exp_c[$], exp_d[$];
   logic [15:0] exp_w[$];
   int rxn_a = 0, rxn_b = 0, rxn_w = 0, dlv_c = 0, dlv_d = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got a word while none was expected", name);
   endtask

   // ---------------- monitors
   always @(negedge clk) begin
      if (!rst && a_rxv) begin
         rxn_a++;
         if (exp_a.size() == 0) unexpected("rx_a");
         else check("rx_a", 32'(a_rxd), 32'(exp_a.pop_front()));
      end
      if (!rst && b_rxv) begin
         rxn_b++;
         if (exp_b.size() == 0) unexpected("rx_b");
         else check("rx_b", 32'(b_rxd), 32'(exp_b.pop_front()));
      end
      if (!rst && w_rxv) begin
         rxn_w++;
         if (exp_w.size() == 0) unexpected("rx_w");
         else check("rx_w", 32'(w_rxd), 32'(exp_w.pop_front()));
      end
   end

   // bench partners for c and d: ack each new request, capture data
   initial begin
      c_pack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) c_pack = 1'b0;
         else if (c_en && c_req && !c_pack) begin
            dlv_c++;
            if (exp_c.size() == 0) unexpected("dlv_c");
            else check("dlv_c", 32'(c_do), 32'(exp_c.pop_front()));
            c_pack = 1'b1;
         end else if (c_pack && !c_req) c_pack = 1'b0;
      end
   end

   initial begin
      d_pack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) d_pack = 1'b0;
         else if (d_en && d_req && !d_pack) begin
            dlv_d++;
            if (exp_d.size() == 0) unexpected("dlv_d");
            else check("dlv_d", 32'(d_do), 32'(exp_d.pop_front()));
            d_pack = 1'b1;
         end else if (d_pack && !d_req) d_pack = 1'b0;
      end
   end

   // ---------------- bounded waits
   function automatic bit cond(input int which);
      case (which)
         0: return !a_busy && !b_busy && !a_req && !b_req && !a_ack_out && !b_ack_out;
         1: return !c_busy && !c_pack;
         2: return !w_busy && !w_ack_out && !w_req;
         3: return d_req;
         4: return d_err;
         5: return !d_busy && !d_pack;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_until(input int which, input int budget, input string name, output int cyc);
      cyc = 0;
      while (!cond(which) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!cond(which)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: condition not reached within %0d cycles", name, budget);
      end
   endtask

   // ---------------- stimulus
   initial begin
      int cyc;
      rst = 1'b1;
      a_tx_valid = 0; b_tx_valid = 0; c_tx_valid = 0; d_tx_valid = 0; w_tx_valid = 0;
      a_tx_data = '0; b_tx_data = '0; c_tx_data = '0; d_tx_data = '0; w_tx_data = '0;
      c_en = 0; d_en = 0; d_clr = 0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_tx_ready", 32'(a_tx_ready), 1);
      check("rst_tx_count", 32'(a_tx_count), 0);
      check("rst_req", 32'(a_req), 0);
      check("rst_ack", 32'(b_ack_out), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_err", 32'(d_err), 0);
      check("rst_rx_data", 32'(b_rxd), 0);
      rst = 1'b0;
      @(negedge clk);

      // single word a -> b with latency
      a_tx_data = 6'h2A; a_tx_valid = 1; exp_b.push_back(6'h2A);
      @(negedge clk);
      a_tx_valid = 0;
      check("t1_count_after_push", 32'(a_tx_count), 1);
      check("t1_req_edge0", 32'(a_req), 0);
      @(negedge clk);
      check("t1_data_edge1", 32'(a_do), 32'h2A);
      check("t1_req_edge1", 32'(a_req), 0);
      @(negedge clk);
      check("t1_req_edge2", 32'(a_req), 1);
      wait_until(0, 60, "t1_idle", cyc);
      check("t1_rx_pulses", 32'(rxn_b), 1);
      check("t1_pending", 32'(exp_b.size()), 0);
      check("t1_count_end", 32'(a_tx_count), 0);
      check("t1_req_end", 32'(a_req), 0);
      check("t1_ack_end", 32'(b_ack_out), 0);

      // simultaneous bidirectional
      a_tx_data = 6'h11; b_tx_data = 6'h22; a_tx_valid = 1; b_tx_valid = 1;
      exp_b.push_back(6'h11); exp_a.push_back(6'h22);
      @(negedge clk);
      a_tx_valid = 0; b_tx_valid = 0;
      wait_until(0, 80, "t2_idle", cyc);
      check("t2_rx_a", 32'(rxn_a), 1);
      check("t2_rx_b", 32'(rxn_b), 2);
      check("t2_pending", 32'(exp_a.size() + exp_b.size()), 0);

      // burst overflow on c, partner ack held low
      for (int i = 0; i < 5; i++) begin
         c_tx_data = 6'(i + 1); c_tx_valid = 1;
         if (i < 4) exp_c.push_back(6'(i + 1));
         @(negedge clk);
         if (i == 2) check("t3_ready_3", 32'(c_tx_ready), 1);
         if (i == 3) begin
            check("t3_ready_full", 32'(c_tx_ready), 0);
            check("t3_count_full", 32'(c_tx_count), 4);
         end
      end
      c_tx_valid = 0;
      check("t3_count_after_5th", 32'(c_tx_count), 4);
      c_en = 1;
      wait_until(1, 300, "t3_idle", cyc);
      check("t3_delivered", 32'(dlv_c), 4);
      check("t3_pending", 32'(exp_c.size()), 0);
      check("t3_count_end", 32'(c_tx_count), 0);
      check("t3_ready_end", 32'(c_tx_ready), 1);

      // wide generic self loop-back
      w_tx_data = 16'hBEEF; w_tx_valid = 1; exp_w.push_back(16'hBEEF);
      @(negedge clk);
      w_tx_data = 16'h1234; exp_w.push_back(16'h1234);
      @(negedge clk);
      w_tx_valid = 0;
      wait_until(2, 200, "t4_idle", cyc);
      check("t4_rx_pulses", 32'(rxn_w), 2);
      check("t4_pending", 32'(exp_w.size()), 0);
      check("t4_count_end", 32'(w_tx_count), 0);

      // timeout retry on d
      d_tx_data = 6'h15; d_tx_valid = 1; exp_d.push_back(6'h15);
      @(negedge clk);
      d_tx_valid = 0;
      wait_until(3, 10, "t5_req", cyc);
      wait_until(4, 30, "t5_timeout", cyc);
      check("t5_timeout_cycles", 32'(cyc), 10);
      check("t5_req_dropped", 32'(d_req), 0);
      check("t5_count_kept", 32'(d_tx_count), 1);
      wait_until(3, 10, "t5_retry_req", cyc);
      check("t5_retry_latency", 32'(cyc), 2);
      check("t5_count_retry", 32'(d_tx_count), 1);
      check("t5_no_delivery_yet", 32'(dlv_d), 0);
      d_clr = 1;
      @(negedge clk);
      d_clr = 0;
      check("t5_err_cleared", 32'(d_err), 0);
      d_en = 1;
      wait_until(5, 60, "t5_idle", cyc);
      check("t5_delivered", 32'(dlv_d), 1);
      check("t5_pending", 32'(exp_d.size()), 0);
      check("t5_err_end", 32'(d_err), 0);
      check("t5_count_end", 32'(d_tx_count), 0);
      check("loop_err_a", 32'(a_err), 0);
      check("loop_err_b", 32'(b_err), 0);

      // reset mid-handshake on d (after a timeout, during retry WAIT_ACK)
      d_en = 0;
      d_tx_data = 6'h2A; d_tx_valid = 1;
      @(negedge clk);
      d_tx_valid = 0;
      wait_until(4, 40, "t6_timeout", cyc);
      wait_until(3, 10, "t6_retry_req", cyc);
      rst = 1'b1;
      @(negedge clk);
      check("t6_req", 32'(d_req), 0);
      check("t6_count", 32'(d_tx_count), 0);
      check("t6_ready", 32'(d_tx_ready), 1);
      check("t6_err", 32'(d_err), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("t6_req_after", 32'(d_req), 0);
      check("t6_busy_after", 32'(d_busy), 0);
      check("t6_no_delivery", 32'(dlv_d), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
